mem_port_arbiter: RTL and testbench

Shares one single-ported backing memory between the pipeline's instruction-fetch requester and its memory-stage data requester. It sits between the fetch/memory stages of the 5-stage MIPS core and a unified memory model. It serialises accesses and gives the data port priority, since that is the older instruction. A starvation counter guarantees fetch forward progress. It also produces the pipeline-wide `stall` used to freeze the fetch→write-back registers while an access is outstanding.

---
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Data has priority; a loss counter forces a fetch grant after MAX_WAIT consecutive losses.
module mem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    input  logic [3:0]    dm_be,
    output logic          dm_ack,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_be,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall,
    output logic [1:0]    owner
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [1:0] OWN_NONE  = 2'd0;
    localparam logic [1:0] OWN_FETCH = 2'd1;
    localparam logic [1:0] OWN_DATA  = 2'd2;
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    state_t        state_q, state_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [1:0]    owner_q, owner_d;
    logic          if_ack_q, if_ack_d;
    logic          dm_ack_q, dm_ack_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;

    logic fetch_forced;
    logic data_wins;

    // Fetch is forced only while it is actually waiting and has lost MAX_WAIT times in a row.
    assign fetch_forced = if_req && (wait_cnt_q == MAX_WAIT_C);
    assign data_wins    = dm_req && !fetch_forced;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        owner_d     = owner_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;

        case (state_q)
            IDLE: begin
                if (!if_req) begin
                    wait_cnt_d = '0;
                end
                if (data_wins) begin
                    state_d     = BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    mem_be_d    = dm_be;
                    owner_d     = OWN_DATA;
                    if (if_req && (wait_cnt_q != MAX_WAIT_C)) begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                end else if (if_req) begin
                    state_d     = BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = 4'h0;
                    owner_d     = OWN_FETCH;
                    wait_cnt_d  = '0;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (owner_q == OWN_DATA) begin
                        dm_ack_d   = 1'b1;
                        dm_rdata_d = mem_we_q ? '0 : mem_rdata;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= 4'h0;
            owner_q     <= OWN_NONE;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            owner_q     <= owner_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign owner     = owner_q;
    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

    // The pipeline must freeze during reset regardless of request state.
    assign stall = reset | (if_req & ~if_ack_q) | (dm_req & ~dm_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [3:0]    dm_be = 4'h0;
    logic          dm_ack;
    logic [DW-1:0] dm_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_ready = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          stall;
    logic [1:0]    owner;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .stall(stall), .owner(owner)
    );

    int errors = 0;
    int checks = 0;
    int txn_count = 0;

    logic [DW-1:0] mem_store [logic [AW-1:0]];

    // Reference model: one outstanding access at a time, described by who owns it.
    bit            m_busy = 0;
    bit            m_resp = 0;
    int            m_who = 0;
    bit            m_we = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [3:0]    m_be = 4'h0;
    int            m_wait_left = 0;
    int            m_losses = 0;
    logic [DW-1:0] exp_if_rdata = '0;
    logic [DW-1:0] exp_dm_rdata = '0;
    int            grant_log[$];

    int            p_if = 0, p_dm = 0, p_reset = 0, max_mem_wait = 0;
    bit            hold_reset = 1, drop_reqs = 0, use_fixed = 0;
    logic [AW-1:0] fixed_if_addr = 32'h100;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic mem_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        logic [DW-1:0] w;
        w = mem_read(a);
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        mem_store[a] = w;
    endtask

    task automatic grant(input int who, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [3:0] be);
        m_busy = 1; m_who = who; m_we = we; m_addr = a; m_wdata = wd; m_be = be;
        m_wait_left = $urandom_range(0, max_mem_wait);
        grant_log.push_back(who);
    endtask

    // One clock cycle: entered and left at a falling edge.
    task automatic step();
        bit exp_if_ack, exp_dm_ack;
        logic [DW-1:0] rd;
        exp_if_ack = m_resp && (m_who == 1);
        exp_dm_ack = m_resp && (m_who == 2);

        check_val("mem_req", mem_req, m_busy);
        if (m_busy) begin
            check_val("mem_addr", mem_addr, m_addr);
            check_val("mem_we", mem_we, m_we);
            if (m_who == 2) begin
                check_val("mem_wdata", mem_wdata, m_wdata);
                check_val("mem_be", mem_be, m_be);
            end
        end
        check_val("owner", owner, (m_busy || m_resp) ? m_who : 0);
        check_val("if_ack", if_ack, exp_if_ack);
        check_val("dm_ack", dm_ack, exp_dm_ack);
        check_val("if_rdata", if_rdata, exp_if_rdata);
        check_val("dm_rdata", dm_rdata, exp_dm_rdata);
        check_val("stall", stall, reset | (if_req & ~exp_if_ack) | (dm_req & ~exp_dm_ack));

        if (exp_if_ack) begin
            txn_count++;
            $display("txn %0d: fetch addr=%h rdata=%h", txn_count, m_addr, exp_if_rdata);
            if_req = 0;
        end
        if (exp_dm_ack) begin
            txn_count++;
            $display("txn %0d: data %s addr=%h wdata=%h be=%h rdata=%h", txn_count,
                     m_we ? "store" : "load", m_addr, m_wdata, m_be, exp_dm_rdata);
            dm_req = 0;
        end
        if (drop_reqs) begin
            if_req = 0;
            dm_req = 0;
        end

        // Fields of the granted requester wander while it waits; they must not reach memory.
        if (m_busy && m_who == 1) if_addr = $urandom;
        if (m_busy && m_who == 2) begin
            dm_addr = $urandom; dm_wdata = $urandom; dm_we = $urandom_range(0, 1);
        end
        if (!if_req && $urandom_range(0, 99) < p_if) begin
            if_req = 1;
            if_addr = use_fixed ? fixed_if_addr : 32'($urandom_range(0, 63)) << 2;
        end
        if (!dm_req && $urandom_range(0, 99) < p_dm) begin
            dm_req = 1;
            dm_we = $urandom_range(0, 1);
            dm_addr = 32'($urandom_range(0, 63)) << 2;
            dm_wdata = $urandom;
            dm_be = 4'($urandom_range(1, 15));
        end

        rd = $urandom;
        mem_ready = 0;
        if (m_busy) begin
            if (m_wait_left == 0) begin
                mem_ready = 1;
                if (!m_we) rd = mem_read(m_addr);
            end else begin
                m_wait_left--;
            end
        end
        mem_rdata = rd;
        reset = hold_reset || ($urandom_range(0, 99) < p_reset);

        // Predict the effect of the coming rising edge.
        if (reset) begin
            m_busy = 0; m_resp = 0; m_losses = 0; m_who = 0;
            exp_if_rdata = '0; exp_dm_rdata = '0;
        end else if (m_resp) begin
            m_resp = 0;
        end else if (m_busy) begin
            if (mem_ready) begin
                m_busy = 0; m_resp = 1;
                if (m_who == 1) exp_if_rdata = rd;
                else begin
                    exp_dm_rdata = m_we ? '0 : rd;
                    if (m_we) mem_write(m_addr, m_wdata, m_be);
                end
            end
        end else if (dm_req && !(if_req && m_losses == MW)) begin
            grant(2, dm_we, dm_addr, dm_wdata, dm_be);
            m_losses = if_req ? ((m_losses < MW) ? m_losses + 1 : MW) : 0;
        end else if (if_req) begin
            grant(1, 1'b0, if_addr, '0, 4'h0);
            m_losses = 0;
        end else begin
            m_losses = 0;
        end

        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input int n);
        p_if = 0; p_dm = 0; p_reset = 0;
        hold_reset = 1; drop_reqs = 1;
        run(n);
        hold_reset = 0; drop_reqs = 0;
    endtask

    int exp_order[6] = '{2, 2, 1, 2, 2, 1};

    initial begin
        mem_store[32'h100] = 32'h2402_000A;
        @(negedge clk);
        @(negedge clk);
        do_reset(2);

        // Fetch only from 0x100 with a zero-wait memory.
        use_fixed = 1; p_if = 100; max_mem_wait = 0;
        run(9);
        use_fixed = 0;
        do_reset(2);

        // Both requesters saturated: grant order follows the fetch loss limit.
        grant_log.delete();
        p_if = 100; p_dm = 100; max_mem_wait = 0;
        run(20);
        for (int i = 0; i < 6; i++)
            check_val("grant_order", (i < grant_log.size()) ? grant_log[i] : 0, exp_order[i]);
        do_reset(2);

        // Random traffic with memory waits.
        p_if = 35; p_dm = 35; max_mem_wait = 3;
        run(600);

        // Random traffic with resets landing anywhere, including mid-access.
        p_reset = 3;
        run(400);
        do_reset(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
